// File: rtl/stream_demux_pkg.sv
// Shared constants and helpers for the 1-to-4 stream demultiplexer.
package stream_demux_pkg;
  localparam int N_OUT = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  // Per-slot state is carried as a valid/data pair inside demux_slot.
  function automatic logic [N_OUT-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    sel_onehot = '0;
    sel_onehot[sel] = 1'b1;
  endfunction
endpackage

// File: rtl/stream_demux_slot.sv
// One output channel: single-entry holding register plus wrapping delivery counter.
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] cnt
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
      cnt_d   = cnt_q + CNT_W'(1);
    end
    // A load wins over the drain so a same-cycle refill keeps the slot full.
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign cnt   = cnt_q;
endmodule

// File: rtl/stream_demux_1_4.sv
// Registered 1-to-4 stream demux: in_sel decode, in_ready mux and four slot instances.
module stream_demux_1_4
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [7:0]       out_cnt0,
  output logic [7:0]       out_cnt1,
  output logic [7:0]       out_cnt2,
  output logic [7:0]       out_cnt3
);
  logic [N_OUT-1:0]             load;
  logic [N_OUT-1:0][WIDTH-1:0]  data_w;
  logic [N_OUT-1:0][CNT_W-1:0]  cnt_w;

  // Head-of-line: only the addressed slot gates the input.
  assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
  assign load     = sel_onehot(in_sel) & {N_OUT{in_valid && in_ready}};

  for (genvar i = 0; i < N_OUT; i++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[i]),
      .load_data (in_data),
      .out_ready (out_ready[i]),
      .valid     (out_valid[i]),
      .data      (data_w[i]),
      .cnt       (cnt_w[i])
    );
  end

  assign out_data0 = data_w[0];
  assign out_data1 = data_w[1];
  assign out_data2 = data_w[2];
  assign out_data3 = data_w[3];
  assign out_cnt0  = cnt_w[0];
  assign out_cnt1  = cnt_w[1];
  assign out_cnt2  = cnt_w[2];
  assign out_cnt3  = cnt_w[3];
endmodule
